// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Multi-cycle issue sequencer sitting in front of the datapath ALU.
//   It accepts one instruction at a time, reads its operands from a
//   synchronous register file, presents the decoded ALU controls and
//   operands, captures the ALU result and writes it back. Arithmetic
//   overflow and undefined opcodes retire the instruction as a trap.
//
// Ports
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   instr_valid/ready : instruction handshake (ready only while idle)
//   instr             : opcode[31:26] rd[25:21] rs[20:16] rt[15:11] imm[15:0]
//   rf_raddr1/2       : register-file read addresses (rs, rt)
//   rf_rdata1/2       : register-file read data, one cycle after address
//   rf_we/waddr/wdata : register-file write port, one-cycle pulse
//   alu_x/alu_y       : ALU operands
//   alu_add_sub       : 0 add, 1 subtract
//   alu_logicfn       : 00 AND, 01 OR, 10 XOR, 11 NOR
//   alu_fn            : 00 arith, 01 logic, 10 set-less-than, 11 pass y
//   alu_result/ovf    : combinational ALU result and signed-overflow flag
//   done              : instruction retired (one-cycle pulse)
//   ovf_trap, illegal : trap causes, pulsed together with done
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_add_sub,
  output logic [1:0]        alu_logicfn,
  output logic [1:0]        alu_fn,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              done,
  output logic              ovf_trap,
  output logic              illegal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    EX   = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR   = 6'h03;
  localparam logic [5:0] OP_XOR  = 6'h04;
  localparam logic [5:0] OP_NOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0B;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  state_t              state_q, state_d;
  logic [31:0]         instr_q, instr_d;
  logic [DATA_W-1:0]   alu_x_q, alu_x_d;
  logic [DATA_W-1:0]   alu_y_q, alu_y_d;
  logic                add_sub_q, add_sub_d;
  logic [1:0]          logicfn_q, logicfn_d;
  logic [1:0]          fn_q, fn_d;
  logic                ovf_en_q, ovf_en_d;
  logic                we_q, we_d;
  logic [REG_AW-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                trap_q, trap_d;
  logic                illegal_q, illegal_d;

  logic                accept;
  logic [5:0]          opcode;
  logic [REG_AW-1:0]   rd_field;
  logic [15:0]         imm;

  assign opcode   = instr_q[31:26];
  assign rd_field = instr_q[21 +: REG_AW];
  assign imm      = instr_q[15:0];

  // The register file is synchronous, so the read addresses are taken
  // straight from the offered instruction in the accept cycle; the data
  // then arrives while we sit in RD. Addresses are forced to zero outside
  // an accept (and during reset) so the port is quiet between instructions.
  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_ready && instr_valid && !rst;
  assign rf_raddr1   = accept ? instr[16 +: REG_AW] : '0;
  assign rf_raddr2   = accept ? instr[11 +: REG_AW] : '0;

  assign alu_x       = alu_x_q;
  assign alu_y       = alu_y_q;
  assign alu_add_sub = add_sub_q;
  assign alu_logicfn = logicfn_q;
  assign alu_fn      = fn_q;
  assign rf_we       = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign done        = done_q;
  assign ovf_trap    = trap_q;
  assign illegal     = illegal_q;

  // Next-state and next-output computation. ALU-facing registers hold
  // their value unless RD decodes a legal instruction, so the operands
  // stay stable through EX and WB and across idle gaps. Retirement
  // strobes default low and are only raised for the WB cycle.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    add_sub_d = add_sub_q;
    logicfn_d = logicfn_q;
    fn_d      = fn_q;
    ovf_en_d  = ovf_en_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    done_d    = 1'b0;
    trap_d    = 1'b0;
    illegal_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          instr_d = instr;
          state_d = RD;
        end
      end

      RD: begin
        state_d   = EX;
        alu_x_d   = rf_rdata1;
        alu_y_d   = rf_rdata2;
        add_sub_d = 1'b0;
        logicfn_d = 2'b00;
        fn_d      = 2'b00;
        ovf_en_d  = 1'b0;
        case (opcode)
          OP_ADD:  ovf_en_d = 1'b1;
          OP_SUB: begin
            add_sub_d = 1'b1;
            ovf_en_d  = 1'b1;
          end
          OP_AND: fn_d = 2'b01;
          OP_OR: begin
            fn_d      = 2'b01;
            logicfn_d = 2'b01;
          end
          OP_XOR: begin
            fn_d      = 2'b01;
            logicfn_d = 2'b10;
          end
          OP_NOR: begin
            fn_d      = 2'b01;
            logicfn_d = 2'b11;
          end
          OP_SLT: begin
            fn_d      = 2'b10;
            add_sub_d = 1'b1;
          end
          OP_ADDI: begin
            alu_y_d  = {{(DATA_W-16){imm[15]}}, imm};
            ovf_en_d = 1'b1;
          end
          OP_ANDI: begin
            alu_y_d = {{(DATA_W-16){1'b0}}, imm};
            fn_d    = 2'b01;
          end
          OP_ORI: begin
            alu_y_d   = {{(DATA_W-16){1'b0}}, imm};
            fn_d      = 2'b01;
            logicfn_d = 2'b01;
          end
          OP_LUI: begin
            alu_y_d = {imm, {(DATA_W-16){1'b0}}};
            fn_d    = 2'b11;
          end
          default: begin
            // Undefined opcode: leave the ALU drive untouched and retire
            // straight away as an illegal-instruction trap.
            alu_x_d   = alu_x_q;
            alu_y_d   = alu_y_q;
            add_sub_d = add_sub_q;
            logicfn_d = logicfn_q;
            fn_d      = fn_q;
            ovf_en_d  = ovf_en_q;
            waddr_d   = rd_field;
            done_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = WB;
          end
        endcase
      end

      EX: begin
        // Operands have been stable for the whole cycle, so the result
        // and overflow flag are captured here. Overflow only matters for
        // the signed add/subtract instructions; writes to r0 are dropped.
        state_d = WB;
        done_d  = 1'b1;
        trap_d  = ovf_en_q && alu_overflow;
        we_d    = !(ovf_en_q && alu_overflow) && (rd_field != '0);
        waddr_d = rd_field;
        wdata_d = alu_result;
      end

      WB: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Single state register for the sequencer and all registered outputs.
  // Reset abandons any instruction in flight; nothing is written back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      add_sub_q <= 1'b0;
      logicfn_q <= 2'b00;
      fn_q      <= 2'b00;
      ovf_en_q  <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      trap_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      add_sub_q <= add_sub_d;
      logicfn_q <= logicfn_d;
      fn_q      <= fn_d;
      ovf_en_q  <= ovf_en_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      trap_q    <= trap_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. Surrounds the sequencer with a
//   synchronous-read register file and a behavioural ALU, then runs a
//   table of instructions with hand-computed results followed by a few
//   hand-written reset sequences.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] alu_x, alu_y;
  logic        alu_add_sub;
  logic [1:0]  alu_logicfn;
  logic [1:0]  alu_fn;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        done, ovf_trap, illegal;

  int assertCount = 0;
  int failCount   = 0;
  int writeCount  = 0;

  logic [31:0] regs [32];
  logic        loadEn;
  logic [4:0]  loadAddr;
  logic [31:0] loadData;

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_x(alu_x), .alu_y(alu_y), .alu_add_sub(alu_add_sub),
    .alu_logicfn(alu_logicfn), .alu_fn(alu_fn),
    .alu_result(alu_result), .alu_overflow(alu_overflow),
    .done(done), .ovf_trap(ovf_trap), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: synchronous read, write from the DUT or the
  // bench preload port, write count kept for the abandoned-write check.
  always @(posedge clk) begin
    rf_rdata1 <= regs[rf_raddr1];
    rf_rdata2 <= regs[rf_raddr2];
    if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
      writeCount     <= writeCount + 1;
    end else if (loadEn) begin
      regs[loadAddr] <= loadData;
    end
  end

  // Behavioural ALU.
  always_comb begin
    logic [31:0] arith;
    arith        = alu_add_sub ? (alu_x - alu_y) : (alu_x + alu_y);
    alu_overflow = alu_add_sub ? ((alu_x[31] != alu_y[31]) && (arith[31] != alu_x[31]))
                               : ((alu_x[31] == alu_y[31]) && (arith[31] != alu_x[31]));
    case (alu_fn)
      2'b00: alu_result = arith;
      2'b01: begin
        case (alu_logicfn)
          2'b00:   alu_result = alu_x & alu_y;
          2'b01:   alu_result = alu_x | alu_y;
          2'b10:   alu_result = alu_x ^ alu_y;
          default: alu_result = ~(alu_x | alu_y);
        endcase
      end
      2'b10:   alu_result = ($signed(alu_x) < $signed(alu_y)) ? 32'd1 : 32'd0;
      default: alu_result = alu_y;
    endcase
  end

  typedef struct {
    string       name;
    logic [31:0] ins;
    bit          legal;
    bit          expWe;
    logic [4:0]  expWaddr;
    logic [31:0] expWdata;
    bit          expTrap;
    bit          expIll;
    logic [1:0]  expFn;
    bit          expAs;
    logic [1:0]  expLf;
    logic [31:0] expY;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [31:0] mkR(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'd0};
  endfunction

  function automatic logic [31:0] mkI(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic loadReg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  // Offer one instruction, then wait (bounded) for done. Returns the
  // number of falling edges from the accept edge to done.
  task automatic applyStimulus(input logic [31:0] ins, output int lat, output bit timedOut);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat      = 0;
    timedOut = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (done) begin
        lat      = i;
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    bit timedOut;
    int savedWrites;

    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    vecs[0]  = '{"add",     mkR(6'h00, 5'd3, 5'd1, 5'd2),   1, 1, 5'd3,  32'd12,         0, 0, 2'b00, 0, 2'b00, 32'd7};
    vecs[1]  = '{"sub_ovf", mkR(6'h01, 5'd4, 5'd8, 5'd9),   1, 0, 5'd4,  32'd0,          1, 0, 2'b00, 1, 2'b00, 32'd1};
    vecs[2]  = '{"addi",    mkI(6'h08, 5'd5, 5'd10, 16'hFFFF), 1, 1, 5'd5, 32'd2,        0, 0, 2'b00, 0, 2'b00, 32'hFFFFFFFF};
    vecs[3]  = '{"ori",     mkI(6'h0B, 5'd6, 5'd0, 16'hFFFF), 1, 1, 5'd6, 32'h0000FFFF,  0, 0, 2'b01, 0, 2'b01, 32'h0000FFFF};
    vecs[4]  = '{"lui",     mkI(6'h0F, 5'd7, 5'd0, 16'h1234), 1, 1, 5'd7, 32'h12340000,  0, 0, 2'b11, 0, 2'b00, 32'h12340000};
    vecs[5]  = '{"slt_r0",  mkR(6'h06, 5'd0, 5'd1, 5'd2),   1, 0, 5'd0,  32'd0,          0, 0, 2'b10, 1, 2'b00, 32'd7};
    vecs[6]  = '{"illegal", mkR(6'h3F, 5'd9, 5'd1, 5'd2),   0, 0, 5'd9,  32'd0,          0, 1, 2'b00, 0, 2'b00, 32'd0};
    vecs[7]  = '{"and",     mkR(6'h02, 5'd11, 5'd1, 5'd2),  1, 1, 5'd11, 32'd5,          0, 0, 2'b01, 0, 2'b00, 32'd7};
    vecs[8]  = '{"xor",     mkR(6'h04, 5'd12, 5'd1, 5'd2),  1, 1, 5'd12, 32'd2,          0, 0, 2'b01, 0, 2'b10, 32'd7};
    vecs[9]  = '{"nor",     mkR(6'h05, 5'd13, 5'd1, 5'd2),  1, 1, 5'd13, 32'hFFFFFFF8,   0, 0, 2'b01, 0, 2'b11, 32'd7};
    vecs[10] = '{"add_r0_ovf", mkR(6'h00, 5'd0, 5'd8, 5'd8), 1, 0, 5'd0, 32'd0,          1, 0, 2'b00, 0, 2'b00, 32'h80000000};
    vecs[11] = '{"slt_noovf", mkR(6'h06, 5'd14, 5'd8, 5'd9), 1, 1, 5'd14, 32'd1,         0, 0, 2'b10, 1, 2'b00, 32'd1};
    vecs[12] = '{"sub_chain", mkR(6'h01, 5'd15, 5'd3, 5'd1), 1, 1, 5'd15, 32'd7,         0, 0, 2'b00, 1, 2'b00, 32'd5};
    vecs[13] = '{"andi",    mkI(6'h0A, 5'd16, 5'd2, 16'h8003), 1, 1, 5'd16, 32'd3,       0, 0, 2'b01, 0, 2'b00, 32'h00008003};
    vecs[14] = '{"add_same", mkR(6'h00, 5'd1, 5'd1, 5'd1),  1, 1, 5'd1,  32'd10,         0, 0, 2'b00, 0, 2'b00, 32'd5};

    // Preload operands while the DUT is held in reset.
    loadReg(5'd1, 32'd5);
    loadReg(5'd2, 32'd7);
    loadReg(5'd8, 32'h80000000);
    loadReg(5'd9, 32'd1);
    loadReg(5'd10, 32'd3);

    #1;
    checkOutput("rst_ready", {31'd0, instr_ready}, 32'd1);
    checkOutput("rst_strobes", {28'd0, done, rf_we, ovf_trap, illegal}, 32'd0);
    checkOutput("rst_alu_ctl", {27'd0, alu_fn, alu_logicfn, alu_add_sub}, 32'd0);
    checkOutput("rst_alu_x", alu_x, 32'd0);
    checkOutput("rst_alu_y", alu_y, 32'd0);

    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].ins, lat, timedOut);
      checkOutput({vecs[v].name, "_done_seen"}, {31'd0, !timedOut}, 32'd1);
      if (vecs[v].legal) checkOutput({vecs[v].name, "_latency"}, lat, 32'd3);
      checkOutput({vecs[v].name, "_we"}, {31'd0, rf_we}, {31'd0, vecs[v].expWe});
      checkOutput({vecs[v].name, "_trap"}, {31'd0, ovf_trap}, {31'd0, vecs[v].expTrap});
      checkOutput({vecs[v].name, "_illegal"}, {31'd0, illegal}, {31'd0, vecs[v].expIll});
      if (vecs[v].expWe) begin
        checkOutput({vecs[v].name, "_waddr"}, {27'd0, rf_waddr}, {27'd0, vecs[v].expWaddr});
        checkOutput({vecs[v].name, "_wdata"}, rf_wdata, vecs[v].expWdata);
      end
      if (vecs[v].legal) begin
        checkOutput({vecs[v].name, "_fn"}, {30'd0, alu_fn}, {30'd0, vecs[v].expFn});
        checkOutput({vecs[v].name, "_y"}, alu_y, vecs[v].expY);
        if (vecs[v].expFn == 2'b01)
          checkOutput({vecs[v].name, "_logicfn"}, {30'd0, alu_logicfn}, {30'd0, vecs[v].expLf});
        else
          checkOutput({vecs[v].name, "_add_sub"}, {31'd0, alu_add_sub}, {31'd0, vecs[v].expAs});
      end
      // One cycle later: strobes gone, ready again, ALU drive held.
      @(negedge clk);
      checkOutput({vecs[v].name, "_after"}, {29'd0, instr_ready, done, rf_we}, 32'b100);
      if (vecs[v].legal)
        checkOutput({vecs[v].name, "_hold_y"}, alu_y, vecs[v].expY);
    end

    // Reset asserted during EX: abandon with no write, outputs cleared.
    savedWrites = writeCount;
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = mkR(6'h00, 5'd17, 5'd1, 5'd2);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rd_not_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    checkOutput("ex_alu_x", alu_x, 32'd10);
    rst = 1'b1;
    #1;
    checkOutput("midrst_alu_x", alu_x, 32'd0);
    checkOutput("midrst_alu_y", alu_y, 32'd0);
    checkOutput("midrst_strobes", {28'd0, done, rf_we, ovf_trap, illegal}, 32'd0);
    checkOutput("midrst_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_write", writeCount, savedWrites);
    checkOutput("midrst_r17", regs[17], 32'd0);

    // Recovery after reset: r1 is 10 now, so 10 + 7.
    applyStimulus(mkR(6'h00, 5'd18, 5'd1, 5'd2), lat, timedOut);
    checkOutput("recover_done_seen", {31'd0, !timedOut}, 32'd1);
    checkOutput("recover_we", {31'd0, rf_we}, 32'd1);
    checkOutput("recover_wdata", rf_wdata, 32'd17);
    @(negedge clk);
    checkOutput("recover_r18", regs[18], 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/control sequencer that drives the datapath ALU: the initiator side of the ALU's x/y/add_sub/LogicFn/fn → ALU_result/Overflow interface.
- Accepts one 32-bit instruction at a time over a valid/ready handshake and reads operands from the register file.
- Decodes the opcode into ALU control, presents the operands, captures the result, and writes it back.
- Flags arithmetic overflow and illegal opcodes.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  32  opcode[31:26], rd[25:21], rs[20:16], rt[15:11], imm[15:0].
- rf_raddr1  out  REG_AW  register-file read address A (rs).
- rf_raddr2  out  REG_AW  register-file read address B (rt).
- rf_rdata1  in  DATA_W  read data A; synchronous, valid 1 cycle after address.
- rf_rdata2  in  DATA_W  read data B; synchronous, valid 1 cycle after address.
- rf_we  out  1  register-file write enable, 1-cycle pulse.
- rf_waddr  out  REG_AW  write address (rd).
- rf_wdata  out  DATA_W  write data.
- alu_x  out  DATA_W  ALU operand x.
- alu_y  out  DATA_W  ALU operand y.
- alu_add_sub  out  1  0 = add, 1 = subtract.
- alu_logicfn  out  2  00 AND, 01 OR, 10 XOR, 11 NOR.
- alu_fn  out  2  result select: 00 arithmetic, 01 logic, 10 set-less-than, 11 pass y.
- alu_result  in  DATA_W  combinational ALU result.
- alu_overflow  in  1  ALU signed-overflow flag.
- done  out  1  1-cycle pulse: instruction retired (normally or with trap).
- ovf_trap  out  1  1-cycle pulse with done: overflow, writeback suppressed.
- illegal  out  1  1-cycle pulse with done: undefined opcode, no writeback.

Behaviour:
- Reset (async, rst=1): state=IDLE. instr_ready=1. All other outputs are 0, including all ALU control outputs, rf_we, done, ovf_trap and illegal. Reset mid-instruction abandons it with no write.
- Opcode map (hex):
  - 00 ADD: fn=00, add_sub=0.
  - 01 SUB: fn=00, add_sub=1.
  - 02 AND, 03 OR, 04 XOR, 05 NOR: fn=01, logicfn=00/01/10/11.
  - 06 SLT: fn=10, add_sub=1.
  - 08 ADDI: y=sign-extended imm, fn=00, add_sub=0.
  - 0A ANDI, 0B ORI: y=zero-extended imm, fn=01.
  - 0F LUI: y={imm,16'h0}, fn=11.
  - All other opcodes are illegal.
- FSM: IDLE → RD → EX → WB → IDLE.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr, drive rf_raddr1=rs and rf_raddr2=rt, go to RD. instr_ready drops the next cycle.
  - RD: decode. Register alu_x=rf_rdata1; register alu_y=rf_rdata2, or the immediate form for I-type. Register the control fields. Illegal opcode: skip to WB with illegal set and no ALU drive change. Go to EX.
  - EX: ALU control and operands are held stable. Sample alu_result and alu_overflow at the end of EX. Overflow is honoured only for ADD/SUB/ADDI; it is ignored for SLT, logic ops and LUI. Go to WB.
  - WB: done=1 for 1 cycle. rf_we=1 and rf_wdata=captured result only if legal, no trap, and rd≠0. Otherwise rf_we=0, with ovf_trap or illegal pulsed. Return to IDLE; instr_ready=1 in the next cycle.
- Latency: accept at cycle N, done at cycle N+3. Throughput is 1 instruction per 4 cycles; instructions never overlap.
- Between instructions, ALU outputs hold their last values; rf_we, done, ovf_trap and illegal are 0.
- rd=0 writes are always suppressed (r0 hard-wired zero). Traps still report on rd=0.
- instr_valid is ignored outside IDLE. A held instr_valid after retirement starts the next instruction from IDLE.
- rs=rt=rd is legal. Read-before-write is guaranteed by sequencing.

Test Plan:
- ADD r3,r1,r2 with r1=5, r2=7 → alu_fn=00, add_sub=0; rf_we at accept+3, waddr=3, wdata=12; done=1; ovf_trap=0.
- SUB r4,r1,r2 with r1=0x80000000, r2=1 → overflow; done=1, ovf_trap=1, rf_we=0.
- ADDI r5,r1,0xFFFF with r1=3 → alu_y=0xFFFFFFFF; wdata=2.
- ORI r6,r0,0xFFFF → alu_y=0x0000FFFF, logicfn=01.
- LUI r7,0x1234 → alu_y=0x12340000, fn=11, wdata=0x12340000.
- SLT into rd=0 → no rf_we, done=1.
- Opcode 0x3F → illegal=1, done=1, rf_we=0.
- Assert rst during EX → all outputs 0 immediately; no write; instr_ready=1 after release.
